// File: rtl/freq_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_mon_pkg
//  Description : Shared types, default constants and the tolerance helper
//                used by the frequency_monitor block.
//                Optional feature macro used by the top: FREQ_MON_MINMAX_EN
//  Revision    : 1.0  initial release
// ============================================================================
package freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_EXP_PERIOD = 16;
    localparam int unsigned DEF_TOL        = 1;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_TIMEOUT    = 64;

    // True when exp_period-tol <= period <= exp_period+tol. Written without a
    // subtraction so a tolerance larger than the expected period cannot underflow.
    function automatic logic in_tol(input int unsigned period,
                                    input int unsigned exp_period,
                                    input int unsigned tol);
        return ((period + tol) >= exp_period) && (period <= (exp_period + tol));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Two-flop synchroniser for an asynchronous input followed by
//                a registered rising-edge detector. The pulse appears on the
//                third clock edge after the input rises.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det
    import freq_mon_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic rise_q;

    // Synchronise, keep one delayed copy, and register the rising-edge pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            meta_q     <= async_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            rise_q     <= sync_q & ~sync_dly_q;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/frequency_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : frequency_monitor
//  Description : Measures the period of an asynchronous monitored clock in
//                clk_50M cycles, declares lock after a run of in-tolerance
//                periods and raises a sticky fault when a locked clock
//                drifts out of tolerance or stalls.
//                Optional macro FREQ_MON_MINMAX_EN adds period_min/period_max
//                extreme trackers (cleared by reset or clr).
//  Revision    : 1.0  initial release
// ============================================================================
module frequency_monitor
    import freq_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clr,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
`ifdef FREQ_MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    localparam int unsigned      GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    logic              w_edge;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_valid_q, period_valid_d;
    logic              fault_q, fault_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    state_e            state_q, state_d;
    logic              w_meas_valid;
    logic              w_in_tol;
    logic              w_stall;
    logic              w_fault_evt;

    sync_edge_det u_sync_edge_det (
        .clk_i   (clk_50M),
        .rst_ni  (rst_n),
        .async_i (clk_in),
        .rise_o  (w_edge)
    );

    // A measurement exists only when an earlier reference edge was taken,
    // which is exactly when the FSM has left IDLE.
    assign w_meas_valid = w_edge && (state_q != IDLE);
    assign w_in_tol     = in_tol(32'(cnt_q), EXP_PERIOD, TOL);
    // An edge in the timeout cycle is a (long) measurement, not a stall.
    assign w_stall      = !w_edge && (cnt_q == TIMEOUT_C);

    // Period counter: restarts on each edge, saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (w_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Capture the elapsed count as the new period when a measurement completes.
    always_comb begin
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (w_meas_valid) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
        end
    end

    // Lock FSM next-state logic; also flags the events that set the fault.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        w_fault_evt = 1'b0;
        case (state_q)
            IDLE: begin
                good_cnt_d = '0;
                if (w_edge) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (w_meas_valid) begin
                    if (w_in_tol) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (w_stall) begin
                    state_d    = IDLE;
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                if ((w_meas_valid && !w_in_tol) || w_stall) begin
                    state_d     = FAULT;
                    w_fault_evt = 1'b1;
                end
            end
            FAULT: begin
                if (w_edge) begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    // Sticky fault: a new fault event overrides a simultaneous clear.
    always_comb begin
        fault_d = fault_q;
        if (w_fault_evt) begin
            fault_d = 1'b1;
        end else if (clr) begin
            fault_d = 1'b0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            good_cnt_q     <= '0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            fault_q        <= fault_d;
        end
    end

    assign edge_pulse   = w_edge;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = (state_q == LOCKED);
    assign fault        = fault_q;

`ifdef FREQ_MON_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    // Extreme tracking; clr restarts from the empty range and a period
    // completing in the same cycle becomes the first sample.
    always_comb begin
        min_d = clr ? CNT_MAX : min_q;
        max_d = clr ? '0      : max_q;
        if (w_meas_valid) begin
            if (cnt_q < min_d) begin
                min_d = cnt_q;
            end
            if (cnt_q > max_d) begin
                max_d = cnt_q;
            end
        end
    end

    // Extreme registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= CNT_MAX;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule
`default_nettype wire
